// File: rtl/uart_csr_bridge_if.sv
// Byte-stream and CSR-bus bundle shared by the UART, uart_csr_bridge and the CSR block.
// The bridge takes the master side; the CSR block / UART model takes the slave side.
interface uart_csr_bridge_if #(
    parameter int ADDR_W = 8
);
    logic              rx_valid;
    logic [7:0]        rx_data;
    logic              tx_valid;
    logic [7:0]        tx_data;
    logic              tx_ready;
    logic              csr_wen;
    logic              csr_ren;
    logic [ADDR_W-1:0] csr_addr;
    logic [31:0]       csr_wdata;
    logic [31:0]       csr_rdata;

    modport master (
        input  rx_valid, rx_data, tx_ready, csr_rdata,
        output tx_valid, tx_data, csr_wen, csr_ren, csr_addr, csr_wdata
    );

    modport slave (
        output rx_valid, rx_data, tx_ready, csr_rdata,
        input  tx_valid, tx_data, csr_wen, csr_ren, csr_addr, csr_wdata
    );
endinterface

// File: rtl/uart_csr_bridge.sv
// Host packet parser driving single-cycle CSR accesses and returning ACK/data/NAK bytes.
// Define UART_BRIDGE_CRC_EN to build the CRC-8 (poly 0x07) packet protection.
module uart_csr_bridge #(
    parameter int ADDR_W      = 8,
    parameter int TIMEOUT_CYC = 100000
) (
    input  logic              clk,
    input  logic              rst_n,
    uart_csr_bridge_if.master bus,
    input  logic              crc_en,
    output logic              rx_crc_error,
    output logic              rx_illegal_cmd,
    output logic              busy
);
    localparam logic [7:0] CMD_WR  = 8'h01;
    localparam logic [7:0] CMD_RD  = 8'h02;
    localparam logic [7:0] RSP_ACK = 8'hA1;
    localparam logic [7:0] RSP_RD  = 8'hA2;
    localparam logic [7:0] RSP_NAK = 8'hEE;
    localparam int         TMO_W   = $clog2(TIMEOUT_CYC + 1);

    typedef enum logic [2:0] {S_IDLE, S_ADDR, S_DATA, S_CRC, S_EXEC, S_RESP} state_t;

    state_t           state, state_nxt;
    logic             is_write;
    logic [1:0]       byte_cnt;
    logic [2:0]       resp_idx, resp_last;
    logic [31:0]      rd_buf;
    logic [7:0]       resp_next;
    logic [TMO_W-1:0] tmo_cnt;
    logic             in_rx_state, rx_acc, timeout, tx_done;
    logic             crc_act, crc_ok;
    logic [7:0]       resp_crc;
    logic             csr_wen_d, csr_ren_d, ill_d, crc_err_d, tx_valid_d;
    logic [7:0]       tx_data_d;

    assign in_rx_state = (state == S_ADDR) || (state == S_DATA) || (state == S_CRC);
    assign rx_acc      = bus.rx_valid && (in_rx_state || (state == S_IDLE));
    assign timeout     = in_rx_state && (tmo_cnt == TMO_W'(TIMEOUT_CYC));
    assign tx_done     = bus.tx_valid && bus.tx_ready;

`ifdef UART_BRIDGE_CRC_EN
    logic [7:0] crc_q;

    function automatic logic [7:0] crc8_upd(input logic [7:0] crc, input logic [7:0] data);
        logic [7:0] c;
        c = crc ^ data;
        for (int i = 0; i < 8; i++) c = c[7] ? ((c << 1) ^ 8'h07) : (c << 1);
        return c;
    endfunction

    assign crc_ok = (bus.rx_data == crc_q);

    // crc_en is frozen at CMD so a mid-packet CSR write cannot change the framing.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            crc_q    <= 8'h00;
            crc_act  <= 1'b0;
            resp_crc <= 8'h00;
        end else begin
            if (rx_acc && (state == S_IDLE)) begin
                crc_q   <= crc8_upd(8'h00, bus.rx_data);
                crc_act <= crc_en;
            end else if (rx_acc && ((state == S_ADDR) || (state == S_DATA))) begin
                crc_q <= crc8_upd(crc_q, bus.rx_data);
            end
            if (state == S_EXEC)
                resp_crc <= crc8_upd(crc8_upd(crc8_upd(crc8_upd(crc8_upd(8'h00, RSP_RD),
                            bus.csr_rdata[7:0]), bus.csr_rdata[15:8]),
                            bus.csr_rdata[23:16]), bus.csr_rdata[31:24]);
        end
    end
`else
    logic unused_crc_en;
    assign unused_crc_en = crc_en;
    assign crc_act       = 1'b0;
    assign crc_ok        = 1'b0;
    assign resp_crc      = 8'h00;
`endif

    // NOTE: non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: if (bus.rx_valid)
                        state_nxt = ((bus.rx_data == CMD_WR) || (bus.rx_data == CMD_RD)) ? S_ADDR : S_RESP;
            S_ADDR: if (bus.rx_valid)
                        state_nxt = is_write ? S_DATA : (crc_act ? S_CRC : S_EXEC);
                    else if (timeout)
                        state_nxt = S_IDLE;
            S_DATA: if (bus.rx_valid) begin
                        if (byte_cnt == 2'd3) state_nxt = crc_act ? S_CRC : S_EXEC;
                    end else if (timeout) begin
                        state_nxt = S_IDLE;
                    end
            S_CRC:  if (bus.rx_valid)
                        state_nxt = crc_ok ? S_EXEC : S_RESP;
                    else if (timeout)
                        state_nxt = S_IDLE;
            S_EXEC: state_nxt = S_RESP;
            S_RESP: if (tx_done && (resp_idx == resp_last)) state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        case (resp_idx)
            3'd0:    resp_next = rd_buf[7:0];
            3'd1:    resp_next = rd_buf[15:8];
            3'd2:    resp_next = rd_buf[23:16];
            3'd3:    resp_next = rd_buf[31:24];
            default: resp_next = resp_crc;
        endcase
    end

    always_comb begin
        // NOTE: every signal gets a default first so no path infers a latch.
        csr_wen_d  = 1'b0;
        csr_ren_d  = 1'b0;
        ill_d      = 1'b0;
        crc_err_d  = 1'b0;
        tx_valid_d = bus.tx_valid;
        tx_data_d  = bus.tx_data;
        if (state_nxt == S_EXEC) begin
            csr_wen_d = is_write;
            csr_ren_d = !is_write;
        end
        case (state)
            S_IDLE: if (state_nxt == S_RESP) begin
                        ill_d      = 1'b1;
                        tx_valid_d = 1'b1;
                        tx_data_d  = RSP_NAK;
                    end
            S_CRC:  if (state_nxt == S_RESP) begin
                        crc_err_d  = crc_act;
                        tx_valid_d = 1'b1;
                        tx_data_d  = RSP_NAK;
                    end
            S_EXEC: begin
                        tx_valid_d = 1'b1;
                        tx_data_d  = is_write ? RSP_ACK : RSP_RD;
                    end
            S_RESP: if (tx_done) begin
                        if (resp_idx == resp_last) tx_valid_d = 1'b0;
                        else                       tx_data_d  = resp_next;
                    end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.tx_valid   <= 1'b0;
            bus.tx_data    <= 8'h00;
            bus.csr_wen    <= 1'b0;
            bus.csr_ren    <= 1'b0;
            bus.csr_addr   <= '0;
            bus.csr_wdata  <= 32'h0;
            rx_crc_error   <= 1'b0;
            rx_illegal_cmd <= 1'b0;
            busy           <= 1'b0;
            is_write       <= 1'b0;
            byte_cnt       <= 2'd0;
            resp_idx       <= 3'd0;
            resp_last      <= 3'd0;
            rd_buf         <= 32'h0;
            tmo_cnt        <= '0;
        end else begin
            bus.tx_valid   <= tx_valid_d;
            bus.tx_data    <= tx_data_d;
            bus.csr_wen    <= csr_wen_d;
            bus.csr_ren    <= csr_ren_d;
            rx_crc_error   <= crc_err_d;
            rx_illegal_cmd <= ill_d;
            busy           <= (state_nxt != S_IDLE);

            if (rx_acc || !in_rx_state) tmo_cnt <= '0;
            else if (!timeout)          tmo_cnt <= tmo_cnt + TMO_W'(1);

            case (state)
                S_IDLE: if (bus.rx_valid) begin
                            is_write  <= (bus.rx_data == CMD_WR);
                            byte_cnt  <= 2'd0;
                            resp_idx  <= 3'd0;
                            resp_last <= 3'd0;
                        end
                S_ADDR: if (bus.rx_valid) bus.csr_addr <= ADDR_W'(bus.rx_data);
                S_DATA: if (bus.rx_valid) begin
                            case (byte_cnt)
                                2'd0:    bus.csr_wdata[7:0]   <= bus.rx_data;
                                2'd1:    bus.csr_wdata[15:8]  <= bus.rx_data;
                                2'd2:    bus.csr_wdata[23:16] <= bus.rx_data;
                                default: bus.csr_wdata[31:24] <= bus.rx_data;
                            endcase
                            byte_cnt <= byte_cnt + 2'd1;
                        end
                S_EXEC: if (!is_write) begin
                            rd_buf    <= bus.csr_rdata;
                            resp_last <= crc_act ? 3'd5 : 3'd4;
                        end
                S_RESP: if (tx_done && (resp_idx != resp_last)) resp_idx <= resp_idx + 3'd1;
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_uart_csr_bridge.sv
// Directed bench for uart_csr_bridge: write/read packets, NAK paths, timeout, backpressure.
// Runs the CRC scenarios when UART_BRIDGE_CRC_EN is defined, the crc_en-ignored case otherwise.
`timescale 1ns/1ps
module tb_uart_csr_bridge;
    localparam int ADDR_W      = 8;
    localparam int TIMEOUT_CYC = 40;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic crc_en = 1'b0;
    logic rx_crc_error, rx_illegal_cmd, busy;

    int checks = 0;
    int errors = 0;

    logic [7:0]  tx_q[$];
    int          wen_cnt, ren_cnt, crc_err_cnt, ill_cnt;

    always #5 clk = ~clk;

    uart_csr_bridge_if #(.ADDR_W(ADDR_W)) bus ();

    uart_csr_bridge #(.ADDR_W(ADDR_W), .TIMEOUT_CYC(TIMEOUT_CYC)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .bus(bus),
        .crc_en(crc_en),
        .rx_crc_error(rx_crc_error),
        .rx_illegal_cmd(rx_illegal_cmd),
        .busy(busy)
    );

    // CSR register file stand-in: read data is combinational from the address.
    always_comb begin
        case (bus.csr_addr)
            8'h3C:   bus.csr_rdata = 32'h0000_0201;
            8'h08:   bus.csr_rdata = 32'h1234_5678;
            default: bus.csr_rdata = 32'hCAFE_F00D;
        endcase
    end

    // Inputs change 1ns after posedge, so the falling edge sees what the next posedge will see.
    always @(negedge clk) begin
        if (rst_n) begin
            if (bus.tx_valid && bus.tx_ready) tx_q.push_back(bus.tx_data);
            if (bus.csr_wen) wen_cnt++;
            if (bus.csr_ren) ren_cnt++;
            if (rx_crc_error) crc_err_cnt++;
            if (rx_illegal_cmd) ill_cnt++;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic clear_mon();
        tx_q.delete();
        wen_cnt = 0;
        ren_cnt = 0;
        crc_err_cnt = 0;
        ill_cnt = 0;
    endtask

    task automatic send_byte(input logic [7:0] b);
        @(posedge clk); #1;
        bus.rx_valid = 1'b1;
        bus.rx_data  = b;
        @(posedge clk); #1;
        bus.rx_valid = 1'b0;
    endtask

    task automatic wait_tx(input int n, input int budget);
        for (int i = 0; i < budget && tx_q.size() < n; i++) @(negedge clk);
        repeat (3) @(negedge clk);
    endtask

    task automatic test_reset();
        bus.rx_valid = 1'b0;
        bus.rx_data  = 8'h00;
        bus.tx_ready = 1'b1;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if ({bus.tx_valid, bus.tx_data, bus.csr_wen, bus.csr_ren, bus.csr_addr, bus.csr_wdata,
             rx_crc_error, rx_illegal_cmd, busy} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got tx_v=%b tx_d=%h wen=%b ren=%b addr=%h wdata=%h crc=%b ill=%b busy=%b, expected all 0",
                     bus.tx_valid, bus.tx_data, bus.csr_wen, bus.csr_ren, bus.csr_addr, bus.csr_wdata,
                     rx_crc_error, rx_illegal_cmd, busy);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if (busy !== 1'b0 || bus.tx_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_release_idle: got busy=%b tx_valid=%b expected 0 0", busy, bus.tx_valid);
        end
    endtask

    task automatic test_write_no_crc();
        clear_mon();
        crc_en = 1'b0;
        send_byte(8'h01);
        send_byte(8'h04);
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL wr_busy_mid_packet: got %b expected 1", busy);
        end
        send_byte(8'h10);
        send_byte(8'h00);
        send_byte(8'h00);
        send_byte(8'h00);
        @(negedge clk);
        checks++;
        if (bus.csr_wen !== 1'b1 || bus.csr_addr !== 8'h04 || bus.csr_wdata !== 32'h0000_0010 || bus.tx_valid !== 1'b0) begin
            errors++;
            $display("FAIL wr_strobe_t1: got wen=%b addr=%h wdata=%h tx_valid=%b expected 1 04 00000010 0",
                     bus.csr_wen, bus.csr_addr, bus.csr_wdata, bus.tx_valid);
        end
        @(negedge clk);
        checks++;
        if (bus.csr_wen !== 1'b0 || bus.tx_valid !== 1'b1 || bus.tx_data !== 8'hA1) begin
            errors++;
            $display("FAIL wr_ack_t2: got wen=%b tx_valid=%b tx_data=%h expected 0 1 a1",
                     bus.csr_wen, bus.tx_valid, bus.tx_data);
        end
        wait_tx(1, 20);
        checks++;
        if (tx_q.size() != 1 || wen_cnt != 1 || ren_cnt != 0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL wr_summary: got tx_bytes=%0d wen=%0d ren=%0d busy=%b expected 1 1 0 0",
                     tx_q.size(), wen_cnt, ren_cnt, busy);
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] exp_b [5] = '{8'hA2, 8'h78, 8'h56, 8'h34, 8'h12};
        clear_mon();
        crc_en = 1'b0;
        bus.tx_ready = 1'b1;
        send_byte(8'h02);
        send_byte(8'h08);
        @(negedge clk);
        checks++;
        if (bus.csr_ren !== 1'b1 || bus.csr_addr !== 8'h08 || bus.csr_wen !== 1'b0) begin
            errors++;
            $display("FAIL rd_strobe_t1: got ren=%b wen=%b addr=%h expected 1 0 08", bus.csr_ren, bus.csr_wen, bus.csr_addr);
        end
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checks++;
            if (bus.tx_valid !== 1'b1 || bus.tx_data !== exp_b[i]) begin
                errors++;
                $display("FAIL rd_b2b_byte%0d: got valid=%b data=%h expected 1 %h", i, bus.tx_valid, bus.tx_data, exp_b[i]);
            end
        end
        @(negedge clk);
        checks++;
        if (bus.tx_valid !== 1'b0 || ren_cnt != 1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL rd_b2b_end: got tx_valid=%b ren=%0d busy=%b expected 0 1 0", bus.tx_valid, ren_cnt, busy);
        end
    endtask

    task automatic test_illegal_cmd();
        logic [7:0] exp_b [6] = '{8'hA2, 8'h01, 8'h02, 8'h00, 8'h00, 8'hF7};
        int n;
        clear_mon();
        crc_en = 1'b0;
        send_byte(8'h55);
        @(negedge clk);
        checks++;
        if (rx_illegal_cmd !== 1'b1) begin
            errors++;
            $display("FAIL ill_pulse_t1: got %b expected 1", rx_illegal_cmd);
        end
        wait_tx(1, 20);
        checks++;
        if (tx_q.size() != 1 || (tx_q.size() > 0 && tx_q[0] !== 8'hEE) || ill_cnt != 1 || wen_cnt + ren_cnt != 0) begin
            errors++;
            $display("FAIL ill_nak: got tx_bytes=%0d first=%h ill=%0d strobes=%0d expected 1 ee 1 0",
                     tx_q.size(), (tx_q.size() > 0) ? tx_q[0] : 8'h00, ill_cnt, wen_cnt + ren_cnt);
        end
        clear_mon();
`ifdef UART_BRIDGE_CRC_EN
        crc_en = 1'b1;
        n = 6;
        send_byte(8'h02);
        send_byte(8'h3C);
        send_byte(8'h9E);
`else
        n = 5;
        send_byte(8'h02);
        send_byte(8'h3C);
`endif
        crc_en = 1'b0;
        wait_tx(n, 30);
        checks++;
        if (tx_q.size() != n || ren_cnt != 1 || ill_cnt != 0) begin
            errors++;
            $display("FAIL ill_followup: got tx_bytes=%0d ren=%0d ill=%0d expected %0d 1 0", tx_q.size(), ren_cnt, ill_cnt, n);
        end
        for (int i = 0; i < n && i < tx_q.size(); i++) begin
            checks++;
            if (tx_q[i] !== exp_b[i]) begin
                errors++;
                $display("FAIL ill_followup_byte%0d: got %h expected %h", i, tx_q[i], exp_b[i]);
            end
        end
    endtask

`ifdef UART_BRIDGE_CRC_EN
    task automatic test_read_crc();
        logic [7:0] exp_b [6] = '{8'hA2, 8'h01, 8'h02, 8'h00, 8'h00, 8'hF7};
        clear_mon();
        crc_en = 1'b1;
        send_byte(8'h02);
        crc_en = 1'b0;
        send_byte(8'h3C);
        send_byte(8'h9E);
        @(negedge clk);
        checks++;
        if (bus.csr_ren !== 1'b1 || bus.csr_addr !== 8'h3C) begin
            errors++;
            $display("FAIL crc_rd_strobe: got ren=%b addr=%h expected 1 3c", bus.csr_ren, bus.csr_addr);
        end
        wait_tx(6, 30);
        checks++;
        if (tx_q.size() != 6 || ren_cnt != 1 || crc_err_cnt != 0) begin
            errors++;
            $display("FAIL crc_rd_summary: got tx_bytes=%0d ren=%0d crc_err=%0d expected 6 1 0", tx_q.size(), ren_cnt, crc_err_cnt);
        end
        for (int i = 0; i < 6 && i < tx_q.size(); i++) begin
            checks++;
            if (tx_q[i] !== exp_b[i]) begin
                errors++;
                $display("FAIL crc_rd_byte%0d: got %h expected %h", i, tx_q[i], exp_b[i]);
            end
        end
    endtask

    task automatic test_bad_crc();
        clear_mon();
        crc_en = 1'b1;
        send_byte(8'h02);
        send_byte(8'h3C);
        send_byte(8'h00);
        @(negedge clk);
        checks++;
        if (rx_crc_error !== 1'b1 || bus.csr_ren !== 1'b0) begin
            errors++;
            $display("FAIL badcrc_pulse_t1: got crc_err=%b ren=%b expected 1 0", rx_crc_error, bus.csr_ren);
        end
        wait_tx(1, 20);
        checks++;
        if (tx_q.size() != 1 || (tx_q.size() > 0 && tx_q[0] !== 8'hEE) || crc_err_cnt != 1 || ren_cnt != 0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL badcrc_nak: got tx_bytes=%0d first=%h crc_err=%0d ren=%0d busy=%b expected 1 ee 1 0 0",
                     tx_q.size(), (tx_q.size() > 0) ? tx_q[0] : 8'h00, crc_err_cnt, ren_cnt, busy);
        end
        crc_en = 1'b0;
    endtask
`else
    task automatic test_crc_ignored();
        logic [7:0] exp_b [5] = '{8'hA2, 8'h01, 8'h02, 8'h00, 8'h00};
        clear_mon();
        crc_en = 1'b1;
        send_byte(8'h02);
        send_byte(8'h3C);
        wait_tx(5, 30);
        checks++;
        if (tx_q.size() != 5 || ren_cnt != 1 || crc_err_cnt != 0) begin
            errors++;
            $display("FAIL nocrc_rd_summary: got tx_bytes=%0d ren=%0d crc_err=%0d expected 5 1 0", tx_q.size(), ren_cnt, crc_err_cnt);
        end
        for (int i = 0; i < 5 && i < tx_q.size(); i++) begin
            checks++;
            if (tx_q[i] !== exp_b[i]) begin
                errors++;
                $display("FAIL nocrc_rd_byte%0d: got %h expected %h", i, tx_q[i], exp_b[i]);
            end
        end
        crc_en = 1'b0;
    endtask
`endif

    task automatic test_timeout();
        clear_mon();
        crc_en = 1'b0;
        send_byte(8'h01);
        send_byte(8'h04);
        repeat (TIMEOUT_CYC / 2) @(negedge clk);
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL tmo_still_busy: got %b expected 1", busy);
        end
        repeat (TIMEOUT_CYC) @(negedge clk);
        checks++;
        if (busy !== 1'b0 || wen_cnt + ren_cnt != 0 || tx_q.size() != 0 || ill_cnt + crc_err_cnt != 0) begin
            errors++;
            $display("FAIL tmo_abort: got busy=%b strobes=%0d tx_bytes=%0d pulses=%0d expected 0 0 0 0",
                     busy, wen_cnt + ren_cnt, tx_q.size(), ill_cnt + crc_err_cnt);
        end
        send_byte(8'h01);
        send_byte(8'h20);
        send_byte(8'hEF);
        send_byte(8'hBE);
        send_byte(8'hAD);
        send_byte(8'hDE);
        @(negedge clk);
        checks++;
        if (bus.csr_wen !== 1'b1 || bus.csr_addr !== 8'h20 || bus.csr_wdata !== 32'hDEAD_BEEF) begin
            errors++;
            $display("FAIL tmo_next_write: got wen=%b addr=%h wdata=%h expected 1 20 deadbeef",
                     bus.csr_wen, bus.csr_addr, bus.csr_wdata);
        end
        wait_tx(1, 20);
        checks++;
        if (tx_q.size() != 1 || (tx_q.size() > 0 && tx_q[0] !== 8'hA1) || wen_cnt != 1) begin
            errors++;
            $display("FAIL tmo_next_ack: got tx_bytes=%0d first=%h wen=%0d expected 1 a1 1",
                     tx_q.size(), (tx_q.size() > 0) ? tx_q[0] : 8'h00, wen_cnt);
        end
    endtask

    task automatic test_backpressure();
        logic [7:0] exp_b [6] = '{8'hA2, 8'h01, 8'h02, 8'h00, 8'h00, 8'hF7};
        logic [7:0] junk [10] = '{8'h01, 8'h00, 8'h55, 8'h00, 8'h02, 8'h00, 8'h3C, 8'h00, 8'h9E, 8'h00};
        int n;
        clear_mon();
        bus.tx_ready = 1'b0;
`ifdef UART_BRIDGE_CRC_EN
        n = 6;
        crc_en = 1'b1;
        send_byte(8'h02);
        send_byte(8'h3C);
        send_byte(8'h9E);
`else
        n = 5;
        send_byte(8'h02);
        send_byte(8'h3C);
`endif
        crc_en = 1'b0;
        for (int i = 0; i < 8 && !bus.tx_valid; i++) @(negedge clk);
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            bus.rx_valid = (i % 2 == 0);
            bus.rx_data  = junk[i];
            @(negedge clk);
            checks++;
            if (bus.tx_valid !== 1'b1 || bus.tx_data !== 8'hA2) begin
                errors++;
                $display("FAIL bp_hold_cycle%0d: got valid=%b data=%h expected 1 a2", i, bus.tx_valid, bus.tx_data);
            end
        end
        @(posedge clk); #1;
        bus.rx_valid = 1'b0;
        bus.tx_ready = 1'b1;
        wait_tx(n, 30);
        checks++;
        if (tx_q.size() != n || ren_cnt != 1 || wen_cnt != 0 || ill_cnt != 0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL bp_summary: got tx_bytes=%0d ren=%0d wen=%0d ill=%0d busy=%b expected %0d 1 0 0 0",
                     tx_q.size(), ren_cnt, wen_cnt, ill_cnt, busy, n);
        end
        for (int i = 0; i < n && i < tx_q.size(); i++) begin
            checks++;
            if (tx_q[i] !== exp_b[i]) begin
                errors++;
                $display("FAIL bp_byte%0d: got %h expected %h", i, tx_q[i], exp_b[i]);
            end
        end
    endtask

    task automatic test_reset_mid_packet();
        clear_mon();
        crc_en = 1'b0;
        send_byte(8'h01);
        send_byte(8'h04);
        send_byte(8'h11);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (10) @(negedge clk);
        checks++;
        if (busy !== 1'b0 || tx_q.size() != 0 || wen_cnt + ren_cnt != 0) begin
            errors++;
            $display("FAIL reset_mid_packet: got busy=%b tx_bytes=%0d strobes=%0d expected 0 0 0",
                     busy, tx_q.size(), wen_cnt + ren_cnt);
        end
    endtask

    initial begin
        clear_mon();
        test_reset();
        test_write_no_crc();
        test_back_to_back();
        test_illegal_cmd();
`ifdef UART_BRIDGE_CRC_EN
        test_read_crc();
        test_bad_crc();
`else
        test_crc_ignored();
`endif
        test_timeout();
        test_backpressure();
        test_reset_mid_packet();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/uart_csr_bridge.md
# uart_csr_bridge

Byte-stream command parser that acts as the initiator of the accelerator's CSR bus. It sits between the UART RX/TX byte interfaces and the CSR block. It decodes host read/write packets, issues single-cycle `csr_wen`/`csr_ren` accesses, and returns ACK, read-data or NAK bytes. It also generates the `rx_crc_error` and `rx_illegal_cmd` event pulses consumed by the CSR status logic.

## Interface
- `ADDR_W`, 8 — CSR byte-address width; the address byte is zero-extended or truncated to this width.
- `TIMEOUT_CYC`, 100000 — maximum idle clocks between bytes inside a packet before the parser aborts.

- `clk` in 1 — clock.
- `rst_n` in 1 — reset, asynchronous, active-low.
- `rx_valid` in 1 — one-cycle strobe marking a received byte. There is no backpressure.
- `rx_data` in 8 — received byte, valid with `rx_valid`.
- `tx_valid` out 1 — response byte available.
- `tx_data` out 8 — response byte.
- `tx_ready` in 1 — UART TX accepts the byte when `tx_valid && tx_ready`.
- `crc_en` in 1 — runtime CRC enable, driven by the CSR `uart_crc_en` field.
- `csr_wen` out 1 — one-cycle CSR write strobe.
- `csr_ren` out 1 — one-cycle CSR read strobe.
- `csr_addr` out ADDR_W — CSR byte address.
- `csr_wdata` out 32 — CSR write data.
- `csr_rdata` in 32 — CSR read data. It is combinational from `csr_addr` and is sampled in the `csr_ren` cycle.
- `rx_crc_error` out 1 — one-cycle pulse on CRC mismatch.
- `rx_illegal_cmd` out 1 — one-cycle pulse on an unknown command byte.
- `busy` out 1 — high whenever the parser state is not IDLE.

## Operation
- **Packet format (host→bridge):**
  - Write: CMD=0x01, ADDR, D0..D3 (little-endian, so D0 = wdata[7:0]), then CRC.
  - Read: CMD=0x02, ADDR, then CRC.
  - The CRC byte is present only when CRC is active (see Configuration).
- **CRC:** CRC-8, polynomial 0x07, init 0x00, MSB-first, no final XOR.
  - Computed over every packet byte before the CRC byte.
  - Updated in the cycle each byte is accepted.
- **States:** IDLE, ADDR, DATA (2-bit byte counter 0..3), CRC, EXEC, RESP (3-bit response byte index).
- **Transitions:**
  - IDLE accepts CMD:
    - 0x01 → ADDR.
    - 0x02 → ADDR.
    - Any other value → pulse `rx_illegal_cmd`, queue NAK, go to RESP.
  - ADDR:
    - Write → DATA.
    - Read → CRC if CRC is active, otherwise → EXEC.
  - DATA: after D3 → CRC if CRC is active, otherwise → EXEC.
  - CRC:
    - Received byte equals the running CRC → EXEC.
    - Mismatch → pulse `rx_crc_error`, queue NAK, go to RESP. No CSR access is issued.
  - EXEC: one cycle.
    - Write: `csr_wen`=1 with `csr_addr`/`csr_wdata`. Queue ACK 0xA1.
    - Read: `csr_ren`=1 and `csr_rdata` is captured into the response buffer. Queue 0xA2, D0..D3, then the CRC-8 of those 5 bytes if CRC is active.
  - RESP: present each queued byte; advance on `tx_ready`. After the last byte → IDLE.
- **Response bytes:** NAK is the single byte 0xEE.
- **Bytes arriving in EXEC or RESP** are discarded silently; parser state and CRC are unchanged.
- **Inter-byte timeout:**
  - A timeout counter clears on every accepted byte and counts while in ADDR, DATA or CRC.
  - When it reaches TIMEOUT_CYC, the parser returns to IDLE silently: no CSR access, no response, no pulse.
- **`crc_en` sampling:** `crc_en` is sampled when CMD is accepted and held for the whole packet.

## Timing
- **Reset values:** every output is 0 (`tx_valid`, `tx_data`, `csr_*`, pulses, `busy`); the state is IDLE and the CRC register is 0x00.
- **Reset mid-packet:** aborts immediately and emits no response.
- **CSR access latency:** if the last packet byte is accepted at cycle t, `csr_wen`/`csr_ren` is high in cycle t+1 only, and the first response byte has `tx_valid`=1 from cycle t+2.
- **Error pulse timing:** `rx_crc_error` and `rx_illegal_cmd` are registered and are high in the cycle after the offending byte.
- **TX handshake:**
  - `tx_data` stays stable while `tx_valid && !tx_ready`.
  - `tx_valid` never drops without a handshake.
  - The next byte is presented in the cycle after the handshake, or back-to-back if `tx_ready` is held high.
- **Outputs:** all outputs are registered.

## Configuration
- **Macro:** `UART_BRIDGE_CRC_EN`.
- **Defined:** CRC is active when `crc_en`=1. With `crc_en`=0, packets carry no CRC byte and read responses carry no trailing CRC.
- **Undefined:**
  - The CRC logic and CRC state are removed.
  - `crc_en` is ignored.
  - Packets never carry a CRC byte and read responses never carry a trailing CRC.
  - `rx_crc_error` is tied to 0.

## Test plan
- **Write, no CRC:** `crc_en`=0, rx 01 04 10 00 00 00 → one-cycle `csr_wen` with addr 0x04, wdata 0x00000010; tx 0xA1.
- **Read with CRC:** macro defined, `crc_en`=1, rx 02 3C 9E, `csr_rdata`=0x00000201 → one-cycle `csr_ren` at addr 0x3C; tx A2 01 02 00 00 followed by the CRC-8 of those bytes.
- **Bad CRC:** rx 02 3C 00 → `rx_crc_error` pulses once; no `csr_ren`; tx 0xEE; parser back in IDLE.
- **Illegal command:** rx 0x55 → `rx_illegal_cmd` pulses once; tx 0xEE. A following 02 3C 9E then completes normally.
- **Timeout:** rx 01 04, then silence for TIMEOUT_CYC cycles → `busy`=0, no CSR strobe, no tx. A following valid packet succeeds.
- **Backpressure and overrun:** hold `tx_ready`=0 for 10 cycles during a read response → `tx_data` stays at 0xA2. Bytes received meanwhile are ignored, and the response completes intact once `tx_ready`=1.
